// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg: shared ALU opcode encoding, width defaults and arbiter FSM states
package alu_share_arbiter_pkg;
  localparam int XLEN_DEF = 32;
  localparam int OPW_DEF = 5;
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_SLT = 5'd5;
  localparam logic [4:0] ALU_SLTU = 5'd6;
  localparam logic [4:0] ALU_SLL = 5'd7;
  localparam logic [4:0] ALU_SRL = 5'd8;
  localparam logic [4:0] ALU_SRA = 5'd9;
  localparam logic [4:0] ALU_NOR = 5'd10;
  localparam logic [4:0] ALU_PASSB = 5'd11;
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
endpackage

// File: rtl/ALU32Bit.sv
// ALU32Bit: combinational 32-bit ALU decoding the shared ALUOp encoding
module ALU32Bit
  import alu_share_arbiter_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  always_comb begin
    case (op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SLT:   y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  y = {31'd0, a < b};
      ALU_SLL:   y = a << b[4:0];
      ALU_SRL:   y = a >> b[4:0];
      ALU_SRA:   y = 32'($signed(a) >>> b[4:0]);
      ALU_NOR:   y = ~(a | b);
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end
endmodule

// File: rtl/alu_share_arbiter_rr_arb2.sv
// alu_share_arbiter_rr_arb2: two-way round-robin grant, ties go to the port not granted last
module alu_share_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic last_q;
  always_comb gnt = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 1'b1;
    else if (advance) last_q <= gnt[1];
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU32Bit between two valid/ready requesters with a registered result
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int OPW = OPW_DEF,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p0_req_valid,
  output logic            p0_req_ready,
  input  logic [XLEN-1:0] p0_a,
  input  logic [XLEN-1:0] p0_b,
  input  logic [OPW-1:0]  p0_op,
  output logic            p0_rsp_valid,
  input  logic            p0_rsp_ready,
  output logic [XLEN-1:0] p0_result,
  input  logic            p1_req_valid,
  output logic            p1_req_ready,
  input  logic [XLEN-1:0] p1_a,
  input  logic [XLEN-1:0] p1_b,
  input  logic [OPW-1:0]  p1_op,
  output logic            p1_rsp_valid,
  input  logic            p1_rsp_ready,
  output logic [XLEN-1:0] p1_result,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);
  state_t state_q, state_d;
  logic owner_q, retire, open;
  logic [1:0] gnt;
  logic [XLEN-1:0] result_q, alu_a, alu_b, alu_y;
  logic [OPW-1:0] alu_op;
  logic [CNTW-1:0] cnt_q;
  always_comb begin
    retire = (state_q == RESP) & (owner_q ? p1_rsp_ready : p0_rsp_ready);
    open = (state_q == IDLE) | retire;
    alu_a = gnt[0] ? p0_a : gnt[1] ? p1_a : '0;
    alu_b = gnt[0] ? p0_b : gnt[1] ? p1_b : '0;
    alu_op = gnt[0] ? p0_op : gnt[1] ? p1_op : '0;
    state_d = (|gnt) ? RESP : retire ? IDLE : state_q;
  end
  alu_share_arbiter_rr_arb2 u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req({p1_req_valid, p0_req_valid} & {2{open}}),
    .advance(|gnt),
    .gnt(gnt)
  );
  ALU32Bit u_alu (
    .op(alu_op),
    .a(alu_a),
    .b(alu_b),
    .y(alu_y)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      result_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (|gnt) begin
        owner_q <= gnt[1];
        result_q <= alu_y;
      end
      if (retire && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end
  always_comb begin
    p0_req_ready = gnt[0];
    p1_req_ready = gnt[1];
    p0_rsp_valid = (state_q == RESP) & ~owner_q;
    p1_rsp_valid = (state_q == RESP) & owner_q;
    p0_result = p0_rsp_valid ? result_q : '0;
    p1_result = p1_rsp_valid ? result_q : '0;
    busy = (state_q == RESP);
    op_count = cnt_q;
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed-vector bench for the shared ALU arbiter (counter width 4)
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;
  logic clk = 0, rst_n = 0;
  logic p0_req_valid = 0, p0_req_ready, p0_rsp_valid, p0_rsp_ready = 0;
  logic p1_req_valid = 0, p1_req_ready, p1_rsp_valid, p1_rsp_ready = 0;
  logic [31:0] p0_a = 0, p0_b = 0, p1_a = 0, p1_b = 0, p0_result, p1_result;
  logic [4:0] p0_op = 0, p1_op = 0;
  logic busy;
  logic [3:0] op_count;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  alu_share_arbiter #(.CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_a(p0_a), .p0_b(p0_b),
    .p0_op(p0_op), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_result(p0_result),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_a(p1_a), .p1_b(p1_b),
    .p1_op(p1_op), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_result(p1_result),
    .busy(busy), .op_count(op_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    rst_n = 1;
    #1;
    chk("rst_p0_req_ready", 32'(p0_req_ready), 0);
    chk("rst_p1_req_ready", 32'(p1_req_ready), 0);
    chk("rst_p0_rsp_valid", 32'(p0_rsp_valid), 0);
    chk("rst_p1_rsp_valid", 32'(p1_rsp_valid), 0);
    chk("rst_p0_result", p0_result, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_count", 32'(op_count), 0);
    // contention: p0 ADD 1+1 = 2, p1 SUB 9-4 = 5, p0 wins the first tie
    p0_req_valid = 1; p0_op = ALU_ADD; p0_a = 1; p0_b = 1; p0_rsp_ready = 1;
    p1_req_valid = 1; p1_op = ALU_SUB; p1_a = 9; p1_b = 4; p1_rsp_ready = 1;
    #1;
    chk("cont_first_p0_ready", 32'(p0_req_ready), 1);
    chk("cont_first_p1_ready", 32'(p1_req_ready), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin p0_req_valid = 0; p1_req_valid = 0; end
      #1;
      if (i % 2 == 0) begin
        chk("cont_p0_rsp_valid", 32'(p0_rsp_valid), 1);
        chk("cont_p0_result", p0_result, 2);
        chk("cont_p1_rsp_valid", 32'(p1_rsp_valid), 0);
        if (i < 3) chk("cont_next_p1_ready", 32'(p1_req_ready), 1);
      end else begin
        chk("cont_p1_rsp_valid", 32'(p1_rsp_valid), 1);
        chk("cont_p1_result", p1_result, 5);
        chk("cont_p0_rsp_valid", 32'(p0_rsp_valid), 0);
        chk("cont_p0_result_zero", p0_result, 0);
        if (i < 3) chk("cont_next_p0_ready", 32'(p0_req_ready), 1);
      end
    end
    tick();
    chk("cont_busy", 32'(busy), 0);
    chk("cont_op_count", 32'(op_count), 4);
    // single request: ADD 5+7
    p0_req_valid = 1; p0_op = ALU_ADD; p0_a = 5; p0_b = 7;
    #1;
    chk("single_req_ready", 32'(p0_req_ready), 1);
    tick();
    p0_req_valid = 0;
    #1;
    chk("single_rsp_valid", 32'(p0_rsp_valid), 1);
    chk("single_result", p0_result, 12);
    chk("single_busy", 32'(busy), 1);
    tick();
    chk("single_op_count", 32'(op_count), 5);
    chk("single_idle_busy", 32'(busy), 0);
    // backpressure: p1 SUB 10-3 held while p0 waits
    p1_req_valid = 1; p1_op = ALU_SUB; p1_a = 10; p1_b = 3; p1_rsp_ready = 0;
    #1;
    chk("bp_p1_req_ready", 32'(p1_req_ready), 1);
    tick();
    p1_req_valid = 0;
    p0_req_valid = 1; p0_op = ALU_ADD; p0_a = 20; p0_b = 22;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_p1_rsp_valid", 32'(p1_rsp_valid), 1);
      chk("bp_p1_result", p1_result, 7);
      chk("bp_p0_req_ready", 32'(p0_req_ready), 0);
      tick();
    end
    p1_rsp_ready = 1;
    #1;
    chk("bp_release_p0_ready", 32'(p0_req_ready), 1);
    chk("bp_release_p1_result", p1_result, 7);
    tick();
    p0_req_valid = 0;
    #1;
    chk("bp_p0_result", p0_result, 42);
    chk("bp_op_count", 32'(op_count), 6);
    tick();
    chk("bp_final_op_count", 32'(op_count), 7);
    // reset while a result is pending
    p0_req_valid = 1; p0_op = ALU_AND; p0_a = 32'hF0F0; p0_b = 32'hFF00; p0_rsp_ready = 0;
    #1;
    chk("rmid_req_ready", 32'(p0_req_ready), 1);
    tick();
    p0_req_valid = 0;
    rst_n = 0;
    #1;
    chk("rmid_result_pending", p0_result, 32'hF000);
    tick();
    rst_n = 1;
    #1;
    chk("rmid_rsp_valid", 32'(p0_rsp_valid), 0);
    chk("rmid_busy", 32'(busy), 0);
    chk("rmid_op_count", 32'(op_count), 0);
    p0_req_valid = 1; p0_op = ALU_XOR; p0_a = 32'hFF; p0_b = 32'h0F; p0_rsp_ready = 1;
    p1_req_valid = 1; p1_op = ALU_OR; p1_a = 1; p1_b = 2;
    #1;
    chk("rmid_tie_p0", 32'(p0_req_ready), 1);
    chk("rmid_tie_p1", 32'(p1_req_ready), 0);
    tick();
    p0_req_valid = 0; p1_req_valid = 0;
    #1;
    chk("rmid_tie_result", p0_result, 32'hF0);
    tick();
    chk("rmid_tie_count", 32'(op_count), 1);
    // saturation: 20 more back-to-back retirements on a 4-bit counter
    p0_req_valid = 1; p1_req_valid = 1;
    for (int j = 0; j < 20; j++) tick();
    p0_req_valid = 0; p1_req_valid = 0;
    tick();
    tick();
    chk("sat_op_count", 32'(op_count), 15);
    // idle
    for (int j = 0; j < 10; j++) tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_p0_rsp_valid", 32'(p0_rsp_valid), 0);
    chk("idle_p1_rsp_valid", 32'(p1_rsp_valid), 0);
    chk("idle_alu_a", dut.alu_a, 0);
    chk("idle_alu_b", dut.alu_b, 0);
    chk("idle_op_count", 32'(op_count), 15);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
